mux_scan_sampler: RTL and testbench

Sequential scan controller that drives the 3-bit select of the existing 8:1 mux (`mux_8to1_2to1only`) and samples its 1-bit output. It steps through channels 0..7 and assembles the eight samples into one 8-bit word, bit k = channel k. Each completed word is delivered on a valid/ready handshake. It sits on both sides of the mux: its `sel` output drives the mux select, and the mux `y` comes back as `mux_y`.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/scan_settle_cnt.sv | 36 +++
 rtl/mux_scan_sampler.sv | 112 +++++++++++
 tb/tb_mux_scan_sampler.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan sampler: FSM state encoding,
// channel count, select width and settle-counter width.
package mux_scan_pkg;

  localparam int N_CH  = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } scan_state_t;

endpackage

// File: rtl/scan_settle_cnt.sv
// Loadable down-counter with zero flag; paces how long the mux select
// is held before each sample.
module scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load takes priority over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sampler.sv
// Steps an external 8:1 mux select through channels 0..7, samples its
// output after a settle interval and hands the 8-bit word out on valid/ready.
module mux_scan_sampler
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_y,
  output logic [2:0] sel,
  output logic [7:0] word,
  output logic       word_valid,
  input  logic       word_ready,
  output logic       busy
);

  // With SETTLE=0 the SETTLE state is skipped and every channel is one SAMPLE cycle.
  localparam logic [CNT_W-1:0] RELOAD   = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
  localparam scan_state_t      FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  scan_state_t      state_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_CH-1:0]  shadow_q;
  logic [N_CH-1:0]  word_q;
  logic             valid_q;
  logic             busy_q;

  logic begin_scan;
  logic last_ch;
  logic cnt_load;
  logic cnt_dec;
  logic cnt_zero;

  assign last_ch    = (sel_q == SEL_W'(N_CH - 1));
  assign begin_scan = ((state_q == ST_IDLE) && start) ||
                      ((state_q == ST_HOLD) && word_ready && cont);
  assign cnt_load   = begin_scan || ((state_q == ST_SAMPLE) && !last_ch);
  assign cnt_dec    = (state_q == ST_SETTLE);

  scan_settle_cnt u_settle_cnt (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (RELOAD),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= FIRST_ST;
          end
        end
        ST_SETTLE: begin
          if (cnt_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          shadow_q[sel_q] <= mux_y;
          // The last channel's bit is merged directly so the word is complete now.
          if (last_ch) begin
            word_q  <= {mux_y, shadow_q[N_CH-2:0]};
            valid_q <= 1'b1;
            state_q <= ST_HOLD;
          end else begin
            sel_q   <= sel_q + SEL_W'(1);
            state_q <= FIRST_ST;
          end
        end
        ST_HOLD: begin
          if (word_ready) begin
            valid_q <= 1'b0;
            if (cont) begin
              sel_q    <= '0;
              shadow_q <= '0;
              state_q  <= FIRST_ST;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign word       = word_q;
  assign word_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Directed bench for mux_scan_sampler: one instance with SETTLE=1 and one
// with SETTLE=0, each fed by a behavioural 8:1 mux.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start1, cont1, ready1, y1, valid1, busy1;
  logic [2:0] sel1;
  logic [7:0] word1, in1;
  logic       start0, cont0, ready0, y0, valid0, busy0;
  logic [2:0] sel0;
  logic [7:0] word0, in0;

  int n_cmp = 0;
  int n_err = 0;

  assign y1 = in1[sel1];
  assign y0 = in0[sel0];

  mux_scan_sampler #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_y(y1),
    .sel(sel1), .word(word1), .word_valid(valid1), .word_ready(ready1), .busy(busy1)
  );

  mux_scan_sampler #(.SETTLE(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .cont(cont0), .mux_y(y0),
    .sel(sel0), .word(word0), .word_valid(valid0), .word_ready(ready0), .busy(busy0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (sel1 !== 3'd0) begin n_err++; $display("FAIL rst_sel: got %0d expected 0", sel1); end
    n_cmp++; if (word1 !== 8'h00) begin n_err++; $display("FAIL rst_word: got %h expected 00", word1); end
    n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", valid1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    // First scan, SETTLE=1: sel 0,0,1,1,...,7,7 then valid after 16 edges.
    in1 = 8'h4D; ready1 = 1'b1; cont1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      n_cmp++;
      if (sel1 !== 3'(n / 2) || valid1 !== 1'b0) begin
        n_err++;
        $display("FAIL scan_seq[%0d]: got sel=%0d valid=%b expected sel=%0d valid=0", n, sel1, valid1, n / 2);
      end
      tick();
    end
    n_cmp++; if (valid1 !== 1'b1) begin n_err++; $display("FAIL first_valid: got %b expected 1", valid1); end
    n_cmp++; if (word1 !== 8'h4D) begin n_err++; $display("FAIL first_word: got %h expected 4d", word1); end
    n_cmp++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL first_busy_hold: got %b expected 1", busy1); end
    tick();
    n_cmp++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL first_release: got valid=%b busy=%b expected 0 0", valid1, busy1); end
    tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL first_busy_low: got %b expected 0", busy1); end
  endtask

  task automatic test_continuous;
    in0 = 8'hA5; cont0 = 1'b1; ready0 = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (sel0 !== 3'(k) || valid0 !== 1'b0) begin
          n_err++;
          $display("FAIL cont_seq[%0d][%0d]: got sel=%0d valid=%b expected sel=%0d valid=0", w, k, sel0, valid0, k);
        end
        tick();
      end
      n_cmp++;
      if (valid0 !== 1'b1 || word0 !== 8'hA5) begin
        n_err++;
        $display("FAIL cont_word[%0d]: got valid=%b word=%h expected 1 a5", w, valid0, word0);
      end
      if (w == 2) cont0 = 1'b0;
      tick();
    end
    n_cmp++; if (busy0 !== 1'b0 || valid0 !== 1'b0) begin n_err++; $display("FAIL cont_stop: got busy=%b valid=%b expected 0 0", busy0, valid0); end
  endtask

  task automatic test_backpressure;
    int cycles;
    in1 = 8'h4D; ready1 = 1'b0; cont1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (16) tick();
    n_cmp++; if (valid1 !== 1'b1 || word1 !== 8'h4D) begin n_err++; $display("FAIL bp_first: got valid=%b word=%h expected 1 4d", valid1, word1); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (word1 !== 8'h4D || sel1 !== 3'd7 || valid1 !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got word=%h sel=%0d valid=%b expected 4d 7 1", i, word1, sel1, valid1);
      end
    end
    in1 = 8'hFF; ready1 = 1'b1;
    tick();
    ready1 = 1'b0; cont1 = 1'b0;
    cycles = 0;
    while (valid1 !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_cmp++; if (cycles !== 16) begin n_err++; $display("FAIL bp_rescan_latency: got %0d expected 16", cycles); end
    n_cmp++; if (word1 !== 8'hFF) begin n_err++; $display("FAIL bp_rescan_word: got %h expected ff", word1); end
    ready1 = 1'b1;
    tick();
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL bp_end_busy: got %b expected 0", busy1); end
  endtask

  task automatic test_reset_midscan;
    int cycles;
    in1 = 8'h4D; cont1 = 1'b0; ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cycles = 0;
    while (sel1 !== 3'd4 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_cmp++; if (cycles !== 8) begin n_err++; $display("FAIL mid_reach_sel4: got %0d cycles expected 8", cycles); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (sel1 !== 3'd0) begin n_err++; $display("FAIL mid_rst_sel: got %0d expected 0", sel1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", busy1); end
    n_cmp++; if (word1 !== 8'h00) begin n_err++; $display("FAIL mid_rst_word: got %h expected 00", word1); end
    n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", valid1); end
    in1 = 8'h3C;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (16) tick();
    n_cmp++; if (valid1 !== 1'b1 || word1 !== 8'h3C) begin n_err++; $display("FAIL mid_restart: got valid=%b word=%h expected 1 3c", valid1, word1); end
    tick();
  endtask

  task automatic test_start_ignored;
    int t;
    int extra;
    in1 = 8'h96; cont1 = 1'b0; ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    t = 0;
    while (sel1 !== 3'd3 && t < 40) begin
      tick();
      t++;
    end
    start1 = 1'b1;
    tick();
    t++;
    start1 = 1'b0;
    while (valid1 !== 1'b1 && t < 60) begin
      tick();
      t++;
    end
    n_cmp++; if (t !== 16) begin n_err++; $display("FAIL ign_latency: got %0d expected 16", t); end
    n_cmp++; if (word1 !== 8'h96) begin n_err++; $display("FAIL ign_word: got %h expected 96", word1); end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_cmp++; if (valid1 !== 1'b1 || sel1 !== 3'd7 || word1 !== 8'h96) begin n_err++; $display("FAIL ign_hold: got valid=%b sel=%0d word=%h expected 1 7 96", valid1, sel1, word1); end
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    n_cmp++; if (busy1 !== 1'b0 || valid1 !== 1'b0) begin n_err++; $display("FAIL ign_release: got busy=%b valid=%b expected 0 0", busy1, valid1); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid1 === 1'b1 || busy1 === 1'b1) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_no_second_word: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_rst_handshake;
    in1 = 8'h4D; cont1 = 1'b1; ready1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (16) tick();
    n_cmp++; if (valid1 !== 1'b1) begin n_err++; $display("FAIL rh_pre_valid: got %b expected 1", valid1); end
    rst = 1'b1; ready1 = 1'b1; start1 = 1'b1;
    tick();
    rst = 1'b0; ready1 = 1'b0; start1 = 1'b0;
    n_cmp++; if (sel1 !== 3'd0 || word1 !== 8'h00) begin n_err++; $display("FAIL rh_data: got sel=%0d word=%h expected 0 00", sel1, word1); end
    n_cmp++; if (valid1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL rh_ctrl: got valid=%b busy=%b expected 0 0", valid1, busy1); end
    repeat (3) tick();
    n_cmp++; if (busy1 !== 1'b0 || valid1 !== 1'b0 || sel1 !== 3'd0) begin n_err++; $display("FAIL rh_idle: got busy=%b valid=%b sel=%0d expected 0 0 0", busy1, valid1, sel1); end
  endtask

  initial begin
    rst = 1'b1;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b0; in1 = 8'h00;
    start0 = 1'b0; cont0 = 1'b0; ready0 = 1'b0; in0 = 8'h00;
    test_reset();
    test_continuous();
    test_backpressure();
    test_reset_midscan();
    test_start_ignored();
    test_rst_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
